// File: rtl/seq_pkg.sv
// Shared types and constants for the per-frame ALU program sequencer.
// Optional immediate operand support is enabled with ALU_SEQ_IMMEDIATE_EN.
package seq_pkg;

    localparam int NUM_REGS = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        EXEC  = ST_EXEC,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } seq_state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int IMM_BIT  = 11;
    localparam int RD_MSB   = 10;
    localparam int RD_LSB   = 8;
    localparam int RS1_MSB  = 6;
    localparam int RS1_LSB  = 4;
    localparam int RS2_MSB  = 2;
    localparam int RS2_LSB  = 0;
    localparam int IMM4_MSB = 3;
    localparam int IMM4_LSB = 0;

    // Bit 7 is reserved; bit 3 is only meaningful as the top of imm4.
    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]   op;
        logic                     imm;
        logic [RD_MSB-RD_LSB:0]   rd;
        logic                     rsv7;
        logic [RS1_MSB-RS1_LSB:0] rs1;
        logic                     imm3;
        logic [RS2_MSB-RS2_LSB:0] rs2;
    } instr_t;

    function automatic logic [IMM4_MSB-IMM4_LSB:0] imm4(input instr_t i);
        return {i.imm3, i.rs2};
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// 8-entry display register file: one synchronous write port,
// two ALU operand read ports and one display read port, all combinational.
module seq_regfile
    import seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr1,
    input  logic [2:0]        raddr2,
    input  logic [2:0]        raddr3,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] rdata3
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A write lands at the clock edge, so readers see it the cycle after.
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign rdata3 = mem[raddr3];

endmodule

// File: rtl/alu_frame_sequencer.sv
// Runs the ROM program through the shared ALU once per vsync rising edge.
// Define ALU_SEQ_IMMEDIATE_EN to let ir[11] select imm4 as operand2.
module alu_frame_sequencer
    import seq_pkg::*;
#(
    parameter int PROG_LEN = 16,
    parameter int DATA_W   = 16,
    parameter int PC_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_v_sync,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [3:0]        alu_operation,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

    seq_state_t        state;
    seq_state_t        state_nx;
    logic              vs_q;
    logic              vs_rise;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_nx;
    instr_t            ir;
    logic              is_halt;
    logic              we;
    logic              exec_live;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [3:0]        opc_q;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] op2_sel;
    logic              ir_unused;

    assign vs_rise   = vga_v_sync & ~vs_q;
    assign is_halt   = (ir.op == OP_HALT);
    assign exec_live = (state == EXEC) && !is_halt;
    assign ir_unused = ^{ir.rsv7, ir.imm, ir.imm3};

`ifdef ALU_SEQ_IMMEDIATE_EN
    assign op2_sel = ir.imm ? DATA_W'(imm4(ir)) : rs2_data;
`else
    assign op2_sel = rs2_data;
`endif

    seq_regfile #(
        .DATA_W (DATA_W)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (ir.rd),
        .wdata  (res_q),
        .raddr1 (ir.rs1),
        .raddr2 (ir.rs2),
        .raddr3 (rd_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .rdata3 (rd_data)
    );

    // The ALU sees live operands in EXEC and the held copies otherwise.
    assign alu_operand1  = exec_live ? rs1_data : op1_q;
    assign alu_operand2  = exec_live ? op2_sel  : op2_q;
    assign alu_operation = exec_live ? ir.op    : opc_q;

    assign prog_addr = pc;
    assign busy      = (state == FETCH) || (state == EXEC) ||
                       (state == WRITE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            vs_q    <= 1'b0;
            pc      <= '0;
            ir      <= '0;
            res_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            vs_q  <= vga_v_sync;
            pc    <= pc_nx;
            if (state == FETCH) begin
                ir <= prog_data;
            end
            if (exec_live) begin
                res_q <= alu_result;
                op1_q <= rs1_data;
                op2_q <= op2_sel;
                opc_q <= ir.op;
            end
            if (vs_rise && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        we       = 1'b0;
        unique case (state)
            IDLE: begin
                if (vs_rise) begin
                    pc_nx    = '0;
                    state_nx = FETCH;
                end
            end
            FETCH: state_nx = EXEC;
            EXEC:  state_nx = WRITE;
            WRITE: begin
                if (is_halt) begin
                    pc_nx    = '0;
                    state_nx = DONE;
                end else if (pc == PC_LAST) begin
                    we       = 1'b1;
                    pc_nx    = '0;
                    state_nx = DONE;
                end else begin
                    we       = 1'b1;
                    pc_nx    = pc + PC_W'(1);
                    state_nx = FETCH;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed self-checking bench for alu_frame_sequencer with a small ALU model
// (op0 add, op1 sub, op2 increment operand1) and a 16-word program ROM.
module tb_alu_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_v_sync;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [15:0] alu_operand1;
    logic [15:0] alu_operand2;
    logic [3:0]  alu_operation;
    logic [15:0] alu_result;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [15:0] rom [16];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] v;

    always #5 clk = ~clk;

    alu_frame_sequencer #(
        .PROG_LEN (16),
        .DATA_W   (16),
        .PC_W     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vga_v_sync    (vga_v_sync),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .alu_operand1  (alu_operand1),
        .alu_operand2  (alu_operand2),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    assign prog_data = rom[prog_addr];

    always_comb begin
        alu_result = 16'h0000;
        case (alu_operation)
            4'h0:    alu_result = alu_operand1 + alu_operand2;
            4'h1:    alu_result = alu_operand1 - alu_operand2;
            4'h2:    alu_result = alu_operand1 + 16'h0001;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 16; i++) rom[i] = w;
    endtask

    // Raise vsync, count cycles to the done pulse; optional second edge and
    // r1 read/write collision sampling at the given cycle numbers.
    task automatic run_frame(input string tag, input int exp_done,
                             input int edge2, input int col_cyc);
        int cyc  = 0;
        bit seen = 0;
        @(negedge clk);
        vga_v_sync = 1'b1;
        while (!seen && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check({tag, "_busy_rise"}, busy, 1);
            if (cyc == 2) vga_v_sync = 1'b0;
            if (edge2 != 0 && cyc == edge2) vga_v_sync = 1'b1;
            if (edge2 != 0 && cyc == edge2 + 2) vga_v_sync = 1'b0;
            if (col_cyc != 0 && cyc == col_cyc)
                check({tag, "_col_old"}, rd_data, 16'd5);
            if (col_cyc != 0 && cyc == col_cyc + 1)
                check({tag, "_col_new"}, rd_data, 16'd8);
            if (done) seen = 1;
        end
        check({tag, "_done_cycle"}, cyc, exp_done);
        check({tag, "_busy_at_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_pc_wrap"}, prog_addr, 0);
    endtask

    initial begin
        logic [15:0] acc_exp;
        reset      = 1'b1;
        vga_v_sync = 1'b0;
        rd_addr    = 3'd0;
        fill_rom(16'hF000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_prog_addr", prog_addr, 0);
        check("rst_alu_op1", alu_operand1, 0);
        check("rst_alu_opc", alu_operation, 0);
        @(negedge clk);
        reset = 1'b0;

        // r1 = r0 + r0, then HALT
        rom[0] = 16'h0100;
        run_frame("single", 7, 0, 0);
        read_reg(3'd1, v);
        check("single_r1", v, 16'd0);

        // r1 = r1 + (imm 3 or r3), then HALT, over four frames
        fill_rom(16'hF000);
        rom[0] = 16'h0913;
        acc_exp = 16'd0;
        for (int f = 0; f < 4; f++) begin
            run_frame("accum", 7, 0, 0);
`ifdef ALU_SEQ_IMMEDIATE_EN
            acc_exp = acc_exp + 16'd3;
`endif
            read_reg(3'd1, v);
            check("accum_r1", v, acc_exp);
        end

        // clear r1/r2, r1 -> 5, r2 -> 3, then r1 = r1 + r2 (write at cycle 33)
        fill_rom(16'hF000);
        rom[0] = 16'h1111;
        rom[1] = 16'h1222;
        for (int i = 2; i < 7; i++) rom[i] = 16'h2110;
        for (int i = 7; i < 10; i++) rom[i] = 16'h2220;
        rom[10] = 16'h0112;
        rd_addr = 3'd1;
        run_frame("collide", 37, 0, 33);
        read_reg(3'd2, v);
        check("collide_r2", v, 16'd3);

        // full-length program: 16 x (r3 = r3 + 1), no HALT
        fill_rom(16'h2330);
        run_frame("full", 49, 0, 0);
        read_reg(3'd3, v);
        check("full_r3", v, 16'd16);
        check("full_no_overrun", overrun, 0);

        run_frame("overrun", 49, 10, 0);
        read_reg(3'd3, v);
        check("overrun_r3", v, 16'd32);
        check("overrun_flag", overrun, 1);

        run_frame("restart", 49, 0, 0);
        read_reg(3'd3, v);
        check("restart_r3", v, 16'd48);
        check("overrun_sticky", overrun, 1);

        // reset while the first instruction is in FETCH
        @(negedge clk);
        vga_v_sync = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_prog_addr", prog_addr, 0);
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], v);
            check("midrst_reg", v, 16'd0);
        end
        @(negedge clk);
        vga_v_sync = 1'b0;
        reset      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
